// File: rtl/m_data_mem.sv
// m_data_mem: MEM-stage word data memory with load/store counters and sticky first-bad-access capture
// Optional store trace under DM_TRACE_EN.
module m_data_mem #(
  parameter int          DEPTH     = 3072,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_PC,
  input  logic [31:0] M_addr,
  input  logic [31:0] M_WD,
  input  logic        M_DM_WE,
  input  logic        M_is_LW,
  output logic [31:0] M_RDATA,
  output logic        M_err,
  output logic [31:0] M_err_pc,
  output logic [31:0] M_err_addr,
  output logic [31:0] M_ld_cnt,
  output logic [31:0] M_st_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   mem [DEPTH];
  logic [31:0]   off, ld_cnt, st_cnt;
  logic [AW-1:0] idx;
  logic          ok, st, ld, bad;
  assign off      = M_addr - BASE_ADDR;
  assign idx      = off[AW+1:2];
  assign ok       = (off < 32'(4 * DEPTH)) && (off[1:0] == 2'b00);
  assign st       = M_DM_WE && ok;
  // a store+load decode counts only as a store
  assign ld       = M_is_LW && ok && !M_DM_WE;
  assign bad      = (M_DM_WE || M_is_LW) && !ok;
  assign M_RDATA  = ok ? mem[idx] : 32'h0;
  assign M_ld_cnt = ld_cnt;
  assign M_st_cnt = st_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ld_cnt     <= '0;
      st_cnt     <= '0;
      M_err      <= 1'b0;
      M_err_pc   <= '0;
      M_err_addr <= '0;
    end else begin
      if (st) mem[idx] <= M_WD;
      if (st) st_cnt <= st_cnt + 32'd1;
      if (ld) ld_cnt <= ld_cnt + 32'd1;
      if (bad && !M_err) begin
        M_err      <= 1'b1;
        M_err_pc   <= M_PC;
        M_err_addr <= M_addr;
      end
`ifdef DM_TRACE_EN
      if (st) $display("%d@%h: *%h <= %h", $time, M_PC, M_addr, M_WD);
`else
`endif
    end
endmodule
